// File: rtl/mc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcode encoding, FSM states
// and default sizing constants.
package mc_datapath_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_REG_N     = 32;
  localparam int DEF_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// R0 hardwired to zero.
module mc_regfile #(
  parameter int DATA_W = 64,
  parameter int REG_N  = 32,
  localparam int RA_W  = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rd_a_addr,
  input  logic [RA_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [REG_N];

  // Entry 0 is reset to zero and never written; the read mux also forces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = (rd_a_addr == '0) ? '0 : regs_q[rd_a_addr];
  assign rd_b_data = (rd_b_addr == '0) ? '0 : regs_q[rd_b_addr];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: IDLE -> READ -> EXEC -> (MEM) -> WB running ADD/SUB on
// the register file and LOAD/STORE against an internal synchronous data memory.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_N     = DEF_REG_N,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  localparam int RA_W     = $clog2(REG_N),
  localparam int MA_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [RA_W-1:0]   ra,
  input  logic [RA_W-1:0]   rb,
  input  logic [RA_W-1:0]   rw,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              addr_err
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [RA_W-1:0]   ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] ex_q, ex_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;
  logic [MA_W-1:0]   mem_idx;

  logic [DATA_W-1:0] rf_a_data, rf_b_data;
  logic [DATA_W-1:0] b_eff, sum, ea;
  logic              ovf_calc;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  mc_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (ra_q),
    .rd_b_addr (rb_q),
    .rd_a_data (rf_a_data),
    .rd_b_data (rf_b_data),
    .wr_en     (rf_we),
    .wr_addr   (rw_q),
    .wr_data   (rf_wdata)
  );

  // SUB is A + (~B + 1) so one overflow rule covers both ALU ops.
  assign b_eff    = (op_q == OP_SUB) ? (~b_q + DATA_W'(1)) : b_q;
  assign sum      = a_q + b_eff;
  assign ovf_calc = (a_q[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
  assign ea       = a_q + imm_q;
  assign mem_idx  = ex_q[MA_W-1:0];

  assign rf_we    = (state_q == ST_WB) && (op_q != OP_STORE);
  assign rf_wdata = (op_q == OP_LOAD) ? mem_rdata_q : ex_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rw_d       = rw_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    ex_d       = ex_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          ra_d    = ra;
          rb_d    = rb;
          rw_d    = rw;
          imm_d   = imm;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        a_d     = rf_a_data;
        b_d     = rf_b_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
          ex_d     = sum;
          result_d = sum;
          ovf_d    = ovf_calc;
          state_d  = ST_WB;
        end else begin
          ex_d    = ea;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        ovf_d      = 1'b0;
        addr_err_d = (ex_q >= DATA_W'(MEM_DEPTH));
        if (op_q == OP_STORE) begin
          result_d = ex_q;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        if (op_q == OP_LOAD) begin
          result_d = mem_rdata_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      ra_q       <= '0;
      rb_q       <= '0;
      rw_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ex_q       <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rw_q       <= rw_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ex_q       <= ex_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory has no reset so its contents survive rst and it maps to block RAM.
  always_ff @(posedge clk) begin
    if (state_q == ST_MEM) begin
      if (op_q == OP_STORE) begin
        mem_q[mem_idx] <= b_q;
      end
      mem_rdata_q <= mem_q[mem_idx];
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_WB);
  // The loaded word only exists in the RAM output register during WB.
  assign result   = ((state_q == ST_WB) && (op_q == OP_LOAD)) ? mem_rdata_q : result_q;
  assign ovf      = ovf_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: per-feature tasks with inline checks.
module tb_mc_datapath;
  import mc_datapath_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  ra, rb, rw;
  logic [63:0] imm;
  logic        busy, done, ovf, addr_err;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  mc_datapath dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rw       (rw),
    .imm      (imm),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .ovf      (ovf),
    .addr_err (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Start on an IDLE cycle, then scramble the command inputs while busy.
  task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] w, input logic [63:0] im);
    @(negedge clk);
    start = 1'b1; op = o; ra = a; rb = b; rw = w; imm = im;
    @(negedge clk);
    start = 1'b0; op = ~o; ra = ~a; rb = ~b; rw = ~w; imm = ~im;
  endtask

  // Cycle 1 is the negedge just after the start-sampling edge; 0 means timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] w, input logic [63:0] im, output int lat);
    issue(o, a, b, w, im);
    wait_done(lat);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
    int lat;
    run(OP_ADD, r, 5'd0, 5'd0, 64'd0, lat);
    v = (lat == 0) ? 64'hxxxx_xxxx_xxxx_xxxx : result;
  endtask

  task automatic preset(input logic [4:0] r, input logic [63:0] val, input logic [5:0] idx);
    int lat;
    @(negedge clk);
    dut.mem_q[idx] = val;
    run(OP_LOAD, 5'd0, 5'd0, r, {58'd0, idx}, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rw = '0; imm = '0;
    for (int i = 0; i < 64; i++) begin
      dut.mem_q[i[5:0]] = 64'd0;
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
    rst = 1'b0;
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_load_empty;
    int lat;
    logic [63:0] v;
    run(OP_LOAD, 5'd0, 5'd0, 5'd1, 64'd5, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL load_latency got %0d want 4", lat); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL load_empty_result got %h want 0", result); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL load_empty_addr_err got %b want 0", addr_err); end
    read_reg(5'd1, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL load_empty_r1 got %h want 0", v); end
    $display("load empty: lat=%0d result=%h R1=%h", lat, result, v);
  endtask

  task automatic test_add_sub;
    int lat;
    logic [63:0] v;
    preset(5'd2, 64'd7, 6'd40);
    preset(5'd3, 64'd5, 6'd41);
    run(OP_ADD, 5'd2, 5'd3, 5'd4, 64'd0, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
    checks++; if (result !== 64'd12) begin errors++; $display("FAIL add_result got %h want c", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got %b want 0", ovf); end
    read_reg(5'd4, v);
    checks++; if (v !== 64'd12) begin errors++; $display("FAIL add_r4 got %h want c", v); end
    $display("add 7+5: lat=%0d result=%h R4=%h", lat, result, v);
    run(OP_SUB, 5'd3, 5'd2, 5'd5, 64'd0, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL sub_latency got %0d want 3", lat); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got %h want fffffffffffffffe", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b want 0", ovf); end
    read_reg(5'd5, v);
    checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_r5 got %h want fffffffffffffffe", v); end
    $display("sub 5-7: result=%h R5=%h", result, v);
  endtask

  task automatic test_overflow;
    int lat;
    preset(5'd2, 64'h7FFF_FFFF_FFFF_FFFF, 6'd42);
    preset(5'd3, 64'd1, 6'd43);
    run(OP_ADD, 5'd2, 5'd3, 5'd8, 64'd0, lat);
    checks++; if (result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_add_result got %h want 8000000000000000", result); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_flag got %b want 1", ovf); end
    $display("add max+1: result=%h ovf=%b", result, ovf);
    preset(5'd9, 64'h8000_0000_0000_0000, 6'd44);
    run(OP_SUB, 5'd9, 5'd3, 5'd10, 64'd0, lat);
    checks++; if (result !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_sub_result got %h want 7fffffffffffffff", result); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sub_flag got %b want 1", ovf); end
    $display("sub min-1: result=%h ovf=%b", result, ovf);
    run(OP_LOAD, 5'd0, 5'd0, 5'd11, 64'd42, lat);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_load got %b want 0", ovf); end
    $display("load after ovf: ovf=%b", ovf);
  endtask

  task automatic test_store_wrap;
    int lat;
    logic [63:0] v;
    preset(5'd6, 64'd32, 6'd45);
    run(OP_STORE, 5'd0, 5'd6, 5'd6, 64'd66, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL store_latency got %0d want 4", lat); end
    checks++; if (result !== 64'd66) begin errors++; $display("FAIL store_ea got %h want 42", result); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL store_addr_err got %b want 1", addr_err); end
    $display("store ea=66: result=%h addr_err=%b", result, addr_err);
    run(OP_LOAD, 5'd0, 5'd0, 5'd7, 64'd2, lat);
    checks++; if (result !== 64'd32) begin errors++; $display("FAIL load_wrapped_result got %h want 20", result); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL load_wrapped_addr_err got %b want 0", addr_err); end
    @(negedge clk);
    checks++; if (result !== 64'd32) begin errors++; $display("FAIL load_result_hold got %h want 20", result); end
    read_reg(5'd7, v);
    checks++; if (v !== 64'd32) begin errors++; $display("FAIL load_r7 got %h want 20", v); end
    read_reg(5'd6, v);
    checks++; if (v !== 64'd32) begin errors++; $display("FAIL store_no_reg_write got %h want 20", v); end
    $display("load mem[2]: R7=%h R6=%h", v, v);
    run(OP_STORE, 5'd0, 5'd6, 5'd0, 64'd63, lat);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ea63_addr_err got %b want 0", addr_err); end
    run(OP_STORE, 5'd0, 5'd6, 5'd0, 64'd64, lat);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ea64_addr_err got %b want 1", addr_err); end
    checks++; if (result !== 64'd64) begin errors++; $display("FAIL ea64_result got %h want 40", result); end
    $display("store ea=63/64 boundary: addr_err=%b", addr_err);
    run(OP_LOAD, 5'd6, 5'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFE2, lat);
    checks++; if (result !== 64'd32) begin errors++; $display("FAIL load_base_offset got %h want 20", result); end
    $display("load 32+(-30): result=%h", result);
  endtask

  task automatic test_r0;
    int lat;
    logic [63:0] v;
    run(OP_ADD, 5'd2, 5'd3, 5'd0, 64'd0, lat);
    read_reg(5'd0, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL r0_write_discarded got %h want 0", v); end
    $display("add into R0: R0=%h", v);
  endtask

  task automatic test_back_to_back;
    int pulses;
    issue(OP_ADD, 5'd2, 5'd3, 5'd12, 64'd0);
    start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) start = 1'b0;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL start_while_busy_pulses got %0d want 1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_while_busy_idle got %b want 0", busy); end
    $display("start during busy: done pulses=%0d", pulses);
  endtask

  task automatic test_mem_retained;
    int lat;
    preset(5'd10, 64'hDEAD_BEEF_0123_4567, 6'd30);
    run(OP_STORE, 5'd0, 5'd10, 5'd0, 64'd20, lat);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(OP_LOAD, 5'd0, 5'd0, 5'd1, 64'd20, lat);
    checks++; if (result !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL mem_kept_over_reset got %h want deadbeef01234567", result); end
    $display("mem[20] after reset: %h", result);
  endtask

  task automatic test_reset_mid;
    int pulses;
    logic [63:0] v;
    preset(5'd2, 64'd7, 6'd40);
    preset(5'd3, 64'd5, 6'd41);
    issue(OP_ADD, 5'd2, 5'd3, 5'd4, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", pulses); end
    read_reg(5'd4, v);
    checks++; if (v !== 64'd0) begin errors++; $display("FAIL abort_r4 got %h want 0", v); end
    $display("reset in EXEC: pulses=%0d R4=%h", pulses, v);
  endtask

  initial begin
    test_reset();
    test_load_empty();
    test_add_sub();
    test_overflow();
    test_store_wrap();
    test_r0();
    test_back_to_back();
    test_mem_retained();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, default 64, operand/register/memory word width.
REQ-002 Parameter REG_N, default 32, register count; RA_W = clog2(REG_N).
REQ-003 Parameter MEM_DEPTH, default 64, data-memory words; MA_W = clog2(MEM_DEPTH).
REQ-004 Port clk  in  1  single clock, all state updates on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port start  in  1  command request, sampled only in IDLE.
REQ-007 Port op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 STORE.
REQ-008 Ports ra, rb, rw  in  RA_W each  source A, source B / store data, destination.
REQ-009 Port imm  in  DATA_W  address offset for LOAD/STORE.
REQ-010 Port busy  out  1  high in every state except IDLE.
REQ-011 Port done  out  1  one-cycle completion pulse.
REQ-012 Port result  out  DATA_W  ALU result (ADD/SUB), loaded word (LOAD), or effective address (STORE).
REQ-013 Port ovf  out  1  signed overflow of the last ADD/SUB.
REQ-014 Port addr_err  out  1  effective address >= MEM_DEPTH on the last LOAD/STORE.

Function
REQ-015 FSM states: IDLE, READ, EXEC, MEM, WB.
REQ-016 IDLE: start=1 latches op/ra/rb/rw/imm and moves to READ; start=0 stays in IDLE.
REQ-017 READ latches A=R[ra] and B=R[rb]; next state is EXEC.
REQ-018 EXEC: ADD computes A+B; SUB computes A-B; LOAD/STORE compute EA=A+imm; all mod 2^DATA_W. Next state: WB for ADD/SUB, MEM for LOAD/STORE.
REQ-019 MEM: memory index = EA[MA_W-1:0] (wrap-around); STORE writes B there; LOAD reads the word. Next state is WB.
REQ-020 WB: ADD/SUB/LOAD write R[rw]; STORE writes no register; done=1 for exactly this cycle; result and flags update on entry to WB; next state is IDLE.
REQ-021 Latency from the start-sampling edge to the done pulse: 3 cycles for ADD/SUB, 4 cycles for LOAD/STORE.
REQ-022 start while busy is ignored and not queued.
REQ-023 R0 always reads 0, and writes to R0 are discarded.
REQ-024 ovf = sign(A)==sign(B') && sign(sum)!=sign(A), where B'=B for ADD and ~B+1 for SUB; ovf=0 for LOAD/STORE.
REQ-025 addr_err=1 when EA >= MEM_DEPTH; the access still proceeds at the wrapped index.
REQ-026 Operands are frozen at READ; later changes to ra/rb/rw/imm/op do not affect the in-flight command.
REQ-027 Memory reads and writes are synchronous; memory is not readable externally except via LOAD.

Reset
REQ-028 rst asserted: FSM=IDLE; busy=0; done=0; result=0; ovf=0; addr_err=0; all registers=0.
REQ-029 rst mid-operation aborts the command: no register write and no done pulse; a memory write already committed in MEM is retained.
REQ-030 Memory contents are not cleared by rst.

Structure
REQ-031 A shared package holds the op encoding (OP_ADD/OP_SUB/OP_LOAD/OP_STORE), the FSM state enum, and default parameter constants.
REQ-032 The register file is one sub-module, mc_regfile: 2 async read ports, 1 sync write port, R0 hardwired to zero, async reset.
REQ-033 Memory is inferred inside mc_datapath; it has no sub-module.

Verification
REQ-034 DATA_W=64. After reset, LOAD ra=0 imm=5 rw=1 on an empty memory -> done at +4 cycles, R1=0, result=0, addr_err=0.
REQ-035 Preset R2=7 and R3=5. ADD ra=2 rb=3 rw=4 -> done at +3 cycles, R4=12, ovf=0; then SUB ra=3 rb=2 rw=5 -> R5=0xFFFF_FFFF_FFFF_FFFE, ovf=0.
REQ-036 R2=0x7FFF_FFFF_FFFF_FFFF, R3=1. ADD -> result=0x8000_0000_0000_0000, ovf=1.
REQ-037 R6=32. STORE ra=0 rb=6 imm=66 -> addr_err=1, mem[2]=32. LOAD ra=0 imm=2 rw=7 -> R7=32.
REQ-038 ADD with rw=0 -> R0 stays 0. A start pulse during busy -> exactly one done pulse.
REQ-039 Assert rst during EXEC of ADD rw=4 -> no done pulse, R4=0, busy=0 on the next cycle.
